// File: rtl/mux_pkg.sv
// Shared types and helpers for the arbitrated N:1 mux and its arbiter.
// The one-hot encoder is sized for the widest channel count the mux supports.
package mux_pkg;

  typedef enum logic {ARB_FIXED, ARB_RR} arb_mode_e;

  localparam int ONEHOT_MAX = 64;

  // Callers narrow the result to their own SEL_W with a size cast.
  function automatic int onehot_to_idx(input logic [ONEHOT_MAX-1:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < ONEHOT_MAX; i++) begin
      if (oh[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/arb_rr.sv
// Request-to-grant arbiter: lowest index wins in fixed mode, rotating
// priority from a registered pointer in round-robin mode.
module arb_rr
  import mux_pkg::*;
#(
  parameter int        N_IN = 4,
  parameter arb_mode_e MODE = ARB_RR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_IN-1:0] req,
  input  logic            advance,
  output logic [N_IN-1:0] grant
);

  localparam int PTR_W = (N_IN > 1) ? $clog2(N_IN) : 1;

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             found;
  int               win;

  // Two ascending passes: first from the pointer to the top, then wrap to 0.
  always_comb begin
    grant = '0;
    found = 1'b0;
    win   = 0;
    for (int i = 0; i < N_IN; i++) begin
      if (!found && req[i] && (i >= int'(ptr_q))) begin
        grant[i] = 1'b1;
        found    = 1'b1;
        win      = i;
      end
    end
    for (int i = 0; i < N_IN; i++) begin
      if (!found && req[i]) begin
        grant[i] = 1'b1;
        found    = 1'b1;
        win      = i;
      end
    end
  end

  // In fixed mode the pointer never leaves 0, so the first pass covers all.
  always_comb begin
    ptr_d = ptr_q;
    if ((MODE == ARB_RR) && advance) begin
      ptr_d = (win == N_IN - 1) ? '0 : PTR_W'(win + 1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/arb_mux.sv
// Arbitrated N:1 mux with valid/ready on every channel and a one-entry
// registered output that can refill in the same cycle it drains.
module arb_mux
  import mux_pkg::*;
#(
  parameter int        N_IN  = 4,
  parameter int        WIDTH = 32,
  parameter arb_mode_e MODE  = ARB_RR,
  localparam int       SEL_W = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_IN-1:0]       in_valid,
  input  logic [N_IN*WIDTH-1:0] in_data,
  output logic [N_IN-1:0]       in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_sel,
  input  logic                  out_ready
);

  logic [N_IN-1:0]       grant;
  logic                  canLoad;
  logic                  inXfer;
  logic [ONEHOT_MAX-1:0] grantWide;
  logic [SEL_W-1:0]      winIdx;
  logic [WIDTH-1:0]      winData;

  logic                  outValid_q, outValid_d;
  logic [WIDTH-1:0]      outData_q, outData_d;
  logic [SEL_W-1:0]      outSel_q, outSel_d;

  arb_rr #(
    .N_IN (N_IN),
    .MODE (MODE)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (in_valid),
    .advance (inXfer),
    .grant   (grant)
  );

  assign canLoad  = !outValid_q || out_ready;
  assign in_ready = grant & {N_IN{canLoad}};
  assign inXfer   = |in_ready;

  // Grant is one-hot or zero, so an AND-OR select suffices for the data.
  always_comb begin
    grantWide            = '0;
    grantWide[N_IN-1:0]  = grant;
    winIdx               = SEL_W'(onehot_to_idx(grantWide));
    winData              = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (grant[i]) winData = winData | in_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    outValid_d = outValid_q;
    outData_d  = outData_q;
    outSel_d   = outSel_q;
    if (inXfer) begin
      outValid_d = 1'b1;
      outData_d  = winData;
      outSel_d   = winIdx;
    end else if (out_ready) begin
      outValid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outValid_q <= 1'b0;
      outData_q  <= '0;
      outSel_q   <= '0;
    end else begin
      outValid_q <= outValid_d;
      outData_q  <= outData_d;
      outSel_q   <= outSel_d;
    end
  end

  assign out_valid = outValid_q;
  assign out_data  = outData_q;
  assign out_sel   = outSel_q;

endmodule

// File: tb/tb_arb_mux.sv
// Self-checking bench for arb_mux: four instances (RR x4, fixed x4, RR x3,
// RR x1) run side by side against a cycle-level reference model.
module tb_arb_mux;
  import mux_pkg::*;

  localparam int NI = 4;

  logic        clk;
  logic        rst;
  logic [3:0]  vIn  [NI];
  logic [31:0] dIn  [NI][4];
  logic        oRdy [NI];

  logic [3:0]  rdy0, rdy1;
  logic [2:0]  rdy2;
  logic [0:0]  rdy3;
  logic        ov0, ov1, ov2, ov3;
  logic [31:0] od0, od1, od2, od3;
  logic [1:0]  os0, os1, os2;
  logic [0:0]  os3;

  logic [3:0]  rdy [NI];
  logic        ov  [NI];
  logic [31:0] od  [NI];
  logic [1:0]  os  [NI];

  int          nCh  [NI] = '{4, 4, 3, 1};
  bit          isRR [NI] = '{1'b1, 1'b0, 1'b1, 1'b1};
  logic        mv   [NI];
  logic [31:0] md   [NI];
  logic [1:0]  ms   [NI];
  int          mp   [NI];

  int testsRun    = 0;
  int testsFailed = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  arb_mux #(.N_IN(4), .WIDTH(32), .MODE(ARB_RR)) u_rr4 (
    .clk(clk), .rst(rst), .in_valid(vIn[0]),
    .in_data({dIn[0][3], dIn[0][2], dIn[0][1], dIn[0][0]}),
    .in_ready(rdy0), .out_valid(ov0), .out_data(od0), .out_sel(os0), .out_ready(oRdy[0]));

  arb_mux #(.N_IN(4), .WIDTH(32), .MODE(ARB_FIXED)) u_fx4 (
    .clk(clk), .rst(rst), .in_valid(vIn[1]),
    .in_data({dIn[1][3], dIn[1][2], dIn[1][1], dIn[1][0]}),
    .in_ready(rdy1), .out_valid(ov1), .out_data(od1), .out_sel(os1), .out_ready(oRdy[1]));

  arb_mux #(.N_IN(3), .WIDTH(32), .MODE(ARB_RR)) u_rr3 (
    .clk(clk), .rst(rst), .in_valid(vIn[2][2:0]),
    .in_data({dIn[2][2], dIn[2][1], dIn[2][0]}),
    .in_ready(rdy2), .out_valid(ov2), .out_data(od2), .out_sel(os2), .out_ready(oRdy[2]));

  arb_mux #(.N_IN(1), .WIDTH(32), .MODE(ARB_RR)) u_rr1 (
    .clk(clk), .rst(rst), .in_valid(vIn[3][0:0]),
    .in_data(dIn[3][0]),
    .in_ready(rdy3), .out_valid(ov3), .out_data(od3), .out_sel(os3), .out_ready(oRdy[3]));

  // Gather the per-instance outputs into arrays for loop-based checking.
  always_comb begin
    rdy[0] = rdy0;  rdy[1] = rdy1;  rdy[2] = {1'b0, rdy2};  rdy[3] = {3'b000, rdy3};
    ov[0]  = ov0;   ov[1]  = ov1;   ov[2]  = ov2;           ov[3]  = ov3;
    od[0]  = od0;   od[1]  = od1;   od[2]  = od2;           od[3]  = od3;
    os[0]  = os0;   os[1]  = os1;   os[2]  = os2;           os[3]  = {1'b0, os3};
  end

  // Winner: scan channels in priority order, starting at the pointer for RR.
  function automatic int winner(int i);
    for (int k = 0; k < nCh[i]; k++) begin
      int c;
      c = isRR[i] ? (mp[i] + k) % nCh[i] : k;
      if (vIn[i][c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [3:0] expReady(int i);
    int w;
    w = winner(i);
    if (w >= 0 && (!mv[i] || oRdy[i])) return 4'(1 << w);
    return 4'b0000;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < NI; i++) begin
      mv[i] = 1'b0;
      md[i] = 32'h0;
      ms[i] = 2'd0;
      mp[i] = 0;
    end
  endtask

  task automatic modelStep();
    if (rst) begin
      modelReset();
    end else begin
      for (int i = 0; i < NI; i++) begin
        int w;
        w = winner(i);
        if (w >= 0 && (!mv[i] || oRdy[i])) begin
          mv[i] = 1'b1;
          md[i] = dIn[i][w];
          ms[i] = 2'(w);
          if (isRR[i]) mp[i] = (w + 1) % nCh[i];
        end else if (mv[i] && oRdy[i]) begin
          mv[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    @(negedge clk);
  endtask

  task automatic setIdle();
    for (int i = 0; i < NI; i++) begin
      vIn[i]  = 4'b0000;
      oRdy[i] = 1'b1;
      for (int c = 0; c < 4; c++) dIn[i][c] = $urandom;
    end
  endtask

  task automatic applyStimulus();
    for (int i = 0; i < NI; i++) begin
      vIn[i]  = 4'($urandom_range(0, 15));
      oRdy[i] = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < 4; c++) dIn[i][c] = $urandom;
    end
  endtask

  task automatic applyReset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    setIdle();
    #2;
    rst = 1'b1;
    #1;
    modelReset();
    for (int i = 0; i < NI; i++) begin
      testsRun++;
      if (ov[i] !== 1'b0 || od[i] !== 32'h0 || os[i] !== 2'd0 || rdy[i] !== 4'b0000) begin
        testsFailed++;
        $display("[TB] FAIL reset inst%0d: got v=%b d=%h s=%0d rdy=%b, expected all zero",
                 i, ov[i], od[i], os[i], rdy[i]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_channel();
    setIdle();
    vIn[0]    = 4'b0100;
    dIn[0][2] = 32'hDEADBEEF;
    #1;
    testsRun++;
    if (rdy[0] !== 4'b0100 || rdy[0] !== expReady(0)) begin
      testsFailed++;
      $display("[TB] FAIL single_ready: got %b expected 0100", rdy[0]);
    end
    tick();
    vIn[0] = 4'b0000;
    testsRun++;
    if (ov[0] !== 1'b1 || od[0] !== 32'hDEADBEEF || os[0] !== 2'd2) begin
      testsFailed++;
      $display("[TB] FAIL single_out: got v=%b d=%h s=%0d expected v=1 d=deadbeef s=2",
               ov[0], od[0], os[0]);
    end
  endtask

  task automatic test_rr_fairness();
    logic [31:0] expData;
    applyReset();
    setIdle();
    vIn[0] = 4'hF;
    for (int k = 0; k < 6; k++) begin
      for (int c = 0; c < 4; c++) dIn[0][c] = $urandom;
      #1;
      testsRun++;
      if (rdy[0] !== 4'(1 << (k % 4)) || rdy[0] !== expReady(0)) begin
        testsFailed++;
        $display("[TB] FAIL rr_ready beat%0d: got %b expected %b", k, rdy[0], 4'(1 << (k % 4)));
      end
      expData = dIn[0][k % 4];
      tick();
      testsRun++;
      if (ov[0] !== 1'b1 || os[0] !== 2'(k % 4) || od[0] !== expData) begin
        testsFailed++;
        $display("[TB] FAIL rr_seq beat%0d: got v=%b s=%0d d=%h expected v=1 s=%0d d=%h",
                 k, ov[0], os[0], od[0], k % 4, expData);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] frozen;
    setIdle();
    tick();
    vIn[0]  = 4'hF;
    oRdy[0] = 1'b0;
    #1;
    testsRun++;
    if (rdy[0] !== 4'b0100 || rdy[0] !== expReady(0)) begin
      testsFailed++;
      $display("[TB] FAIL bp_first_ready: got %b expected 0100", rdy[0]);
    end
    frozen = dIn[0][2];
    tick();
    for (int s = 0; s < 5; s++) begin
      for (int c = 0; c < 4; c++) dIn[0][c] = $urandom;
      #1;
      testsRun++;
      if (rdy[0] !== 4'b0000) begin
        testsFailed++;
        $display("[TB] FAIL bp_stall_ready cyc%0d: got %b expected 0000", s, rdy[0]);
      end
      tick();
      testsRun++;
      if (ov[0] !== 1'b1 || os[0] !== 2'd2 || od[0] !== frozen) begin
        testsFailed++;
        $display("[TB] FAIL bp_hold cyc%0d: got v=%b s=%0d d=%h expected v=1 s=2 d=%h",
                 s, ov[0], os[0], od[0], frozen);
      end
    end
    oRdy[0] = 1'b1;
    #1;
    testsRun++;
    if (rdy[0] !== 4'b1000 || rdy[0] !== expReady(0)) begin
      testsFailed++;
      $display("[TB] FAIL bp_resume_ready: got %b expected 1000", rdy[0]);
    end
    frozen = dIn[0][3];
    tick();
    testsRun++;
    if (ov[0] !== 1'b1 || os[0] !== 2'd3 || od[0] !== frozen) begin
      testsFailed++;
      $display("[TB] FAIL bp_resume_out: got v=%b s=%0d d=%h expected v=1 s=3 d=%h",
               ov[0], os[0], od[0], frozen);
    end
  endtask

  task automatic test_fixed();
    logic [31:0] expData;
    setIdle();
    vIn[1] = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 4; c++) dIn[1][c] = $urandom;
      #1;
      testsRun++;
      if (rdy[1] !== 4'b0010) begin
        testsFailed++;
        $display("[TB] FAIL fixed_ready beat%0d: got %b expected 0010", k, rdy[1]);
      end
      expData = dIn[1][1];
      tick();
      testsRun++;
      if (ov[1] !== 1'b1 || os[1] !== 2'd1 || od[1] !== expData) begin
        testsFailed++;
        $display("[TB] FAIL fixed_out beat%0d: got v=%b s=%0d d=%h expected v=1 s=1 d=%h",
                 k, ov[1], os[1], od[1], expData);
      end
    end
    vIn[1] = 4'b1000;
    #1;
    testsRun++;
    if (rdy[1] !== 4'b1000) begin
      testsFailed++;
      $display("[TB] FAIL fixed_starved_ready: got %b expected 1000", rdy[1]);
    end
    expData = dIn[1][3];
    tick();
    testsRun++;
    if (ov[1] !== 1'b1 || os[1] !== 2'd3 || od[1] !== expData) begin
      testsFailed++;
      $display("[TB] FAIL fixed_starved_out: got v=%b s=%0d d=%h expected v=1 s=3 d=%h",
               ov[1], os[1], od[1], expData);
    end
  endtask

  task automatic test_wrap();
    logic [3:0]  pat  [4] = '{4'b0011, 4'b0011, 4'b0101, 4'b0101};
    int          expW [4] = '{0, 1, 2, 0};
    logic [31:0] expData;
    applyReset();
    setIdle();
    for (int k = 0; k < 4; k++) begin
      vIn[2] = pat[k];
      #1;
      testsRun++;
      if (rdy[2] !== 4'(1 << expW[k]) || rdy[2] !== expReady(2)) begin
        testsFailed++;
        $display("[TB] FAIL wrap_ready step%0d: got %b expected %b", k, rdy[2], 4'(1 << expW[k]));
      end
      expData = dIn[2][expW[k]];
      tick();
      testsRun++;
      if (ov[2] !== 1'b1 || os[2] !== 2'(expW[k]) || od[2] !== expData) begin
        testsFailed++;
        $display("[TB] FAIL wrap_out step%0d: got v=%b s=%0d d=%h expected v=1 s=%0d d=%h",
                 k, ov[2], os[2], od[2], expW[k], expData);
      end
    end
  endtask

  task automatic test_pipe1();
    setIdle();
    for (int k = 0; k < 24; k++) begin
      vIn[3]    = {3'b000, 1'($urandom_range(0, 1))};
      oRdy[3]   = ($urandom_range(0, 3) != 0);
      dIn[3][0] = $urandom;
      #1;
      testsRun++;
      if (rdy[3] !== expReady(3)) begin
        testsFailed++;
        $display("[TB] FAIL pipe1_ready cyc%0d: got %b expected %b", k, rdy[3], expReady(3));
      end
      tick();
      testsRun++;
      if (ov[3] !== mv[3] || od[3] !== md[3] || os[3] !== 2'd0) begin
        testsFailed++;
        $display("[TB] FAIL pipe1_out cyc%0d: got v=%b d=%h s=%0d expected v=%b d=%h s=0",
                 k, ov[3], od[3], os[3], mv[3], md[3]);
      end
    end
  endtask

  task automatic test_reset_midstream();
    setIdle();
    vIn[0]  = 4'hF;
    oRdy[0] = 1'b0;
    for (int c = 0; c < 4; c++) dIn[0][c] = $urandom | 32'h1;
    tick();
    testsRun++;
    if (ov[0] !== 1'b1 || od[0] !== md[0]) begin
      testsFailed++;
      $display("[TB] FAIL midrst_preload: got v=%b d=%h expected v=1 d=%h", ov[0], od[0], md[0]);
    end
    #2;
    rst = 1'b1;
    #1;
    modelReset();
    for (int i = 0; i < NI; i++) begin
      testsRun++;
      if (ov[i] !== 1'b0 || od[i] !== 32'h0 || os[i] !== 2'd0) begin
        testsFailed++;
        $display("[TB] FAIL midrst_async inst%0d: got v=%b d=%h s=%0d expected all zero",
                 i, ov[i], od[i], os[i]);
      end
    end
    tick();
    rst     = 1'b0;
    oRdy[0] = 1'b1;
    #1;
    testsRun++;
    if (rdy[0] !== 4'b0001) begin
      testsFailed++;
      $display("[TB] FAIL midrst_first_ready: got %b expected 0001", rdy[0]);
    end
    tick();
    testsRun++;
    if (ov[0] !== 1'b1 || os[0] !== 2'd0 || od[0] !== dIn[0][0]) begin
      testsFailed++;
      $display("[TB] FAIL midrst_first_out: got v=%b s=%0d d=%h expected v=1 s=0 d=%h",
               ov[0], os[0], od[0], dIn[0][0]);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      applyStimulus();
      #1;
      for (int i = 0; i < NI; i++) begin
        testsRun++;
        if (rdy[i] !== expReady(i)) begin
          testsFailed++;
          $display("[TB] FAIL rand_ready inst%0d cyc%0d: got %b expected %b",
                   i, k, rdy[i], expReady(i));
        end
      end
      tick();
      for (int i = 0; i < NI; i++) begin
        testsRun++;
        if (ov[i] !== mv[i] || od[i] !== md[i] || os[i] !== ms[i]) begin
          testsFailed++;
          $display("[TB] FAIL rand_out inst%0d cyc%0d: got v=%b d=%h s=%0d expected v=%b d=%h s=%0d",
                   i, k, ov[i], od[i], os[i], mv[i], md[i], ms[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_channel();
    test_rr_fairness();
    test_backpressure();
    test_fixed();
    test_wrap();
    test_pipe1();
    test_reset_midstream();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
